// File: rtl/key_loader.sv
// ---------------------------------------------------------------------------
// key_loader
//   Receives a serial key (MSB first, optional trailing even-parity bit) and
//   presents it as a write-once parallel key for a locked controller.
//
// Parameters
//   KEY_W   width of the parallel key (2..32)
//   PAR_EN  1 = an even-parity bit follows the key bits, 0 = no parity bit
//   TMO     maximum number of consecutive idle cycles between key bits
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   key_start    one-cycle pulse that begins (or restarts) a key load
//   key_bit      serial key data, MSB first, parity bit last
//   key_bit_vld  key_bit is valid this cycle
//   key_out      parallel key, non-zero only while a checked key is held
//   key_valid    key_out holds a checked key
//   busy         a load is in progress (shift or parity phase)
//   err          the last load failed (parity mismatch or timeout)
// ---------------------------------------------------------------------------
module key_loader #(
  parameter int KEY_W  = 8,
  parameter int PAR_EN = 1,
  parameter int TMO    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_bit_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int IDLE_W = $clog2(TMO + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0]  BIT_ONE   = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TMO - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  // Even parity: the parity bit makes the total number of ones even,
  // so the expected parity bit is the XOR-reduction of the key.
  function automatic logic even_parity(input logic [KEY_W-1:0] value);
    return ^value;
  endfunction

  logic [2:0]        state_r,     state_nxt_s;
  logic [KEY_W-1:0]  sr_r,        sr_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r,   bit_cnt_nxt_s;
  logic [IDLE_W-1:0] idle_cnt_r,  idle_cnt_nxt_s;
  logic [KEY_W-1:0]  key_out_r,   key_out_nxt_s;
  logic              key_valid_r, key_valid_nxt_s;
  logic [KEY_W-1:0]  sr_shift_s;

  assign sr_shift_s = {sr_r[KEY_W-2:0], key_bit};

  // Next-state, datapath and output-register update rules.
  always_comb begin
    state_nxt_s     = state_r;
    sr_nxt_s        = sr_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    idle_cnt_nxt_s  = idle_cnt_r;
    key_out_nxt_s   = key_out_r;
    key_valid_nxt_s = key_valid_r;

    case (state_r)
      S_IDLE: begin
        // Serial bits are ignored until a load is started.
        if (key_start) begin
          state_nxt_s    = S_SHIFT;
          sr_nxt_s       = '0;
          bit_cnt_nxt_s  = '0;
          idle_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_SHIFT: begin
        // key_start wins over a same-cycle bit: that bit is discarded.
        if (key_start) begin
          state_nxt_s    = S_SHIFT;
          sr_nxt_s       = '0;
          bit_cnt_nxt_s  = '0;
          idle_cnt_nxt_s = '0;
        end else if (key_bit_vld) begin
          idle_cnt_nxt_s = '0;
          sr_nxt_s       = sr_shift_s;
          bit_cnt_nxt_s  = bit_cnt_r + BIT_ONE;
          if (bit_cnt_r == BIT_LAST) begin
            if (PAR_EN != 0) begin
              state_nxt_s = S_PARITY;
            end else begin
              // Without parity the key is accepted with its last bit.
              state_nxt_s     = S_LOCKED;
              key_out_nxt_s   = sr_shift_s;
              key_valid_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = S_SHIFT;
          end
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_nxt_s    = S_ERROR;
          idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
        end
      end

      S_PARITY: begin
        if (key_start) begin
          state_nxt_s    = S_SHIFT;
          sr_nxt_s       = '0;
          bit_cnt_nxt_s  = '0;
          idle_cnt_nxt_s = '0;
        end else if (key_bit_vld) begin
          idle_cnt_nxt_s = '0;
          if (key_bit == even_parity(sr_r)) begin
            state_nxt_s     = S_LOCKED;
            key_out_nxt_s   = sr_r;
            key_valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_ERROR;
          end
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_nxt_s    = S_ERROR;
          idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
        end
      end

      S_LOCKED: begin
        // Write-once: only reset leaves this state.
        state_nxt_s = S_LOCKED;
      end

      S_ERROR: begin
        key_out_nxt_s   = '0;
        key_valid_nxt_s = 1'b0;
        if (key_start) begin
          state_nxt_s    = S_SHIFT;
          sr_nxt_s       = '0;
          bit_cnt_nxt_s  = '0;
          idle_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = S_ERROR;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle state.
        state_nxt_s     = S_IDLE;
        sr_nxt_s        = '0;
        bit_cnt_nxt_s   = '0;
        idle_cnt_nxt_s  = '0;
        key_out_nxt_s   = '0;
        key_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      sr_r        <= '0;
      bit_cnt_r   <= '0;
      idle_cnt_r  <= '0;
      key_out_r   <= '0;
      key_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sr_r        <= sr_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      idle_cnt_r  <= idle_cnt_nxt_s;
      key_out_r   <= key_out_nxt_s;
      key_valid_r <= key_valid_nxt_s;
    end
  end

  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  // Status flags are pure decodes of the registered state.
  assign busy      = (state_r == S_SHIFT) || (state_r == S_PARITY);
  assign err       = (state_r == S_ERROR);

endmodule

// File: tb/tb_key_loader.sv
// ---------------------------------------------------------------------------
// tb_key_loader
//   Drives two key_loader instances (parity enabled / disabled) with the
//   same serial stream. A transaction-level reference model predicts each
//   cycle's outputs into per-instance queues; an independent monitor pops
//   and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_key_loader;

  localparam int KW  = 8;
  localparam int TMO = 16;

  typedef struct packed {
    logic [KW-1:0] key;
    logic          kv;
    logic          busy;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_start = 1'b0;
  logic key_bit = 1'b0;
  logic key_bit_vld = 1'b0;

  logic [KW-1:0] ko0, ko1;
  logic kv0, kv1, bz0, bz1, er0, er1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Model state per instance: phase 0 idle, 1 loading, 2 locked, 3 error.
  int            m_phase[2];
  int            m_cnt[2];
  int            m_idle[2];
  logic [KW-1:0] m_acc[2];

  always #5 clk = ~clk;

  key_loader #(.KEY_W(KW), .PAR_EN(1), .TMO(TMO)) dut0 (
    .clk(clk), .rst(rst), .key_start(key_start), .key_bit(key_bit),
    .key_bit_vld(key_bit_vld), .key_out(ko0), .key_valid(kv0),
    .busy(bz0), .err(er0)
  );

  key_loader #(.KEY_W(KW), .PAR_EN(0), .TMO(TMO)) dut1 (
    .clk(clk), .rst(rst), .key_start(key_start), .key_bit(key_bit),
    .key_bit_vld(key_bit_vld), .key_out(ko1), .key_valid(kv1),
    .busy(bz1), .err(er1)
  );

  // Reference model: advance one clock for instance idx, return outputs.
  function automatic exp_t model(input int idx, input bit par_en,
                                 input logic r, input logic s,
                                 input logic v, input logic b);
    exp_t e;
    if (r) begin
      m_phase[idx] = 0; m_cnt[idx] = 0; m_idle[idx] = 0; m_acc[idx] = '0;
    end else if (m_phase[idx] == 0 || m_phase[idx] == 3) begin
      if (s) begin
        m_phase[idx] = 1; m_cnt[idx] = 0; m_idle[idx] = 0; m_acc[idx] = '0;
      end
    end else if (m_phase[idx] == 1) begin
      if (s) begin
        m_cnt[idx] = 0; m_idle[idx] = 0; m_acc[idx] = '0;
      end else if (v) begin
        m_idle[idx] = 0;
        if (m_cnt[idx] == KW) begin
          // Parity bit: total ones across key and parity must be even.
          if (($countones(m_acc[idx]) + int'(b)) % 2 == 0) m_phase[idx] = 2;
          else m_phase[idx] = 3;
        end else begin
          m_acc[idx] = {m_acc[idx][KW-2:0], b};
          m_cnt[idx] = m_cnt[idx] + 1;
          if (m_cnt[idx] == KW && !par_en) m_phase[idx] = 2;
        end
      end else begin
        m_idle[idx] = m_idle[idx] + 1;
        if (m_idle[idx] == TMO) m_phase[idx] = 3;
      end
    end
    e.key  = (m_phase[idx] == 2) ? m_acc[idx] : '0;
    e.kv   = (m_phase[idx] == 2);
    e.busy = (m_phase[idx] == 1);
    e.err  = (m_phase[idx] == 3);
    return e;
  endfunction

  task automatic step(input logic r, input logic s, input logic v, input logic b);
    @(negedge clk);
    rst = r; key_start = s; key_bit_vld = v; key_bit = b;
    @(posedge clk);
    #1;
    q0.push_back(model(0, 1'b1, r, s, v, b));
    q1.push_back(model(1, 1'b0, r, s, v, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [KW-1:0] val, input int nbits, input int gap);
    for (int i = KW - 1; i >= KW - nbits; i--) begin
      step(1'b0, 1'b0, 1'b1, val[i]);
      idle(gap);
    end
  endtask

  task automatic load(input logic [KW-1:0] val, input logic par, input int gap);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(val, KW, gap);
    step(1'b0, 1'b0, 1'b1, par);
    idle(2);
  endtask

  // Monitor: compare each presented output tuple against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_cmp++;
      if ({ko0, kv0, bz0, er0} !== e) begin
        n_bad++;
        $display("FAIL par1_outputs t=%0t got key=%h kv=%b busy=%b err=%b expected key=%h kv=%b busy=%b err=%b",
                 $time, ko0, kv0, bz0, er0, e.key, e.kv, e.busy, e.err);
      end
      n_cmp++;
      if (kv0 === 1'b1 && er0 === 1'b1) begin
        n_bad++;
        $display("FAIL par1_exclusive t=%0t got kv=1 err=1 expected not both", $time);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_cmp++;
      if ({ko1, kv1, bz1, er1} !== e) begin
        n_bad++;
        $display("FAIL par0_outputs t=%0t got key=%h kv=%b busy=%b err=%b expected key=%h kv=%b busy=%b err=%b",
                 $time, ko1, kv1, bz1, er1, e.key, e.kv, e.busy, e.err);
      end
    end
  end

  initial begin
    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // 0xA5 with correct parity 0.
    load(8'hA5, 1'b0, 0);

    // 0xA5 with wrong parity, then retry from error.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    load(8'hA5, 1'b1, 0);
    load(8'hA5, 1'b0, 0);

    // 0x3C with 3 idle cycles between bits.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    load(8'h3C, 1'b0, 3);

    // Stall of TMO idle cycles after 4 bits times out.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'hB6, 4, 0);
    idle(TMO + 2);

    // Restart after 5 bits, then 0xF0; restart cycle carries a discarded bit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'hFF, 5, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    send_bits(8'hF0, KW, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Locked key is write-once.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    load(8'hA5, 1'b0, 0);
    load(8'h00, 1'b0, 0);

    // Reset mid-load, stray bits without start, then 0x81.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'h6B, 6, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(8'hC3, KW, 0);
    idle(2);
    load(8'h81, 1'b0, 0);

    // Randomized rounds: random bits/parity, occasional restarts and stalls.
    for (int rnd = 0; rnd < 40; rnd++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
        logic s, v, b;
        s = ($urandom_range(0, 24) == 0);
        v = ($urandom_range(0, 9) < 8);
        b = 1'($urandom_range(0, 1));
        if (rnd % 5 == 4 && c == 4) idle(TMO + $urandom_range(0, 1) - 1);
        step(1'b0, s, v, b);
      end
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 8, width of the parallel key delivered to the locked FSM; legal range 2..32.
REQ-002 Parameter PAR_EN, default 1, 1 = a trailing even-parity bit follows the key bits, 0 = no parity bit.
REQ-003 Parameter TMO, default 16, maximum number of consecutive idle cycles allowed between key bits.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port key_start  input  1  one-cycle pulse that begins a key load.
REQ-007 Port key_bit  input  1  serial key data; MSB first; parity bit last.
REQ-008 Port key_bit_vld  input  1  key_bit is valid this cycle.
REQ-009 Port key_out  output  KEY_W  parallel key; drives the keyinput bits of the locked controller.
REQ-010 Port key_valid  output  1  key_out holds a checked key.
REQ-011 Port busy  output  1  high in states SHIFT and PARITY.
REQ-012 Port err  output  1  high in state ERROR.

Function
REQ-013 The block SHALL implement five states: IDLE, SHIFT, PARITY, LOCKED and ERROR.
REQ-014 In IDLE, key_start SHALL clear the shift register, bit counter and idle counter, and the block SHALL enter SHIFT; key_bit_vld SHALL be ignored.
REQ-015 In SHIFT, each cycle with key_bit_vld=1 SHALL shift key_bit into the LSB (sr = {sr[KEY_W-2:0], key_bit}) and increment the bit counter.
REQ-016 When the KEY_W-th bit is accepted, the next state SHALL be PARITY if PAR_EN=1; otherwise it SHALL be LOCKED.
REQ-017 In PARITY, the next valid bit SHALL be compared with the XOR-reduction of the shift register. Match -> LOCKED. Mismatch -> ERROR.
REQ-018 On entry to LOCKED, key_out SHALL load the shift register value and key_valid SHALL be 1 from the cycle after the final bit is sampled.
REQ-019 key_out and key_valid SHALL hold unchanged in LOCKED until rst.
REQ-020 In LOCKED, key_start and key_bit_vld SHALL be ignored; the key is write-once.
REQ-021 In SHIFT, key_start SHALL take priority over key_bit_vld in the same cycle: the block SHALL restart, clearing the counters and shift register, and the bit presented in that cycle SHALL be discarded.
REQ-022 In PARITY, key_start SHALL cause the same restart into SHIFT.
REQ-023 In SHIFT and PARITY, the idle counter SHALL increment on every cycle with key_bit_vld=0 and SHALL clear on every cycle with key_bit_vld=1.
REQ-024 When the idle counter reaches TMO, the block SHALL enter ERROR.
REQ-025 In ERROR: err=1, key_valid=0, key_out=0.
REQ-026 In ERROR, key_start SHALL clear err in the next cycle and the block SHALL enter SHIFT (retry).
REQ-027 key_valid and err SHALL never both be 1 in the same cycle.
REQ-028 busy SHALL be decoded from the registered state only.
REQ-029 All outputs SHALL be registered or decoded from the registered state only; there SHALL be no combinational path from input to output.

Reset
REQ-030 When rst=1 at a clock edge: state SHALL be IDLE; key_out, key_valid, busy and err SHALL be 0; the shift register and all counters SHALL be 0.
REQ-031 rst SHALL override every other input, including in the middle of a load and in LOCKED.

Verification
REQ-032 KEY_W=8, PAR_EN=1: key_start, then bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0 -> key_out=0xA5 and key_valid=1 one cycle after the parity bit; err=0.
REQ-033 Same key 0xA5 with parity 1 -> err=1, key_valid=0, key_out=0x00; a following key_start plus a correct load -> key_out=0xA5, key_valid=1.
REQ-034 Load 0x3C with 3 idle cycles between bits -> key_out=0x3C; a separate load stalled for 16 idle cycles after 4 bits -> err=1.
REQ-035 key_start after 5 accepted bits, then a full load of 0xF0 with parity 0 -> key_out=0xF0; the first 5 bits have no effect.
REQ-036 After LOCKED with 0xA5, a new key_start and load of 0x00 -> key_out stays 0xA5 and key_valid stays 1.
REQ-037 rst asserted after 6 bits of a load -> all outputs 0 on the next cycle; bits without key_start are ignored; PAR_EN=0 load of 0x81 -> key_valid=1 the cycle after the 8th bit.
